// File: rtl/maze_pkg.sv
// Shared encodings for the LED-matrix maze controller.
package maze_pkg;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_WIN     = 2'd1,
    ST_CRASH   = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter: load, enable, freeze, stops at 00 and flags it.
module bcd_down_counter #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_en,
  input  logic       i_freeze,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_zero
);
  import maze_pkg::*;

  logic [3:0] r_tens, r_ones;

  assign o_tens = r_tens;
  assign o_ones = r_ones;
  assign o_zero = ({r_tens, r_ones} == BCD_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_tens, r_ones} <= RST_VAL;
    end else if (i_load) begin
      {r_tens, r_ones} <= i_load_val;
    end else if (i_en && !i_freeze && !o_zero) begin
      if (r_ones == 4'd0) begin
        r_ones <= 4'd9;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: position tracking, wall collision, BCD countdown, outcome FSM.
// Optional MAZE_LIVES_EN: wall hits cost a life and respawn until lives run out.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int GRID      = 8,
  parameter int TIME_SEC  = 20,
  parameter int START_ROW = 7,
  parameter int START_COL = 0,
  parameter int EXIT_ROW  = 0,
  parameter int EXIT_COL  = 5,
  parameter int LIVES     = 3,
  localparam int PW       = $clog2(GRID)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sec_tick,
  input  logic                 start,
  input  logic                 mv_up,
  input  logic                 mv_down,
  input  logic                 mv_left,
  input  logic                 mv_right,
  input  logic [GRID*GRID-1:0] wall_map,
  output logic [PW-1:0]        pos_row,
  output logic [PW-1:0]        pos_col,
  output logic [1:0]           state,
  output logic [3:0]           time_tens,
  output logic [3:0]           time_ones,
  output logic [3:0]           lives_left,
  output logic                 done
);

  localparam int IW = $clog2(GRID * GRID);
  localparam logic [7:0] TIME_BCD = to_bcd(TIME_SEC);
`ifdef MAZE_LIVES_EN
  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
`else
  localparam logic [3:0] LIVES_INIT = 4'(LIVES) & 4'd0;
`endif
  localparam logic [PW-1:0] ST_R = PW'(START_ROW);
  localparam logic [PW-1:0] ST_C = PW'(START_COL);

  state_t        r_state;
  logic [PW-1:0] r_row, r_col;
  logic [3:0]    r_lives;
  logic          r_done;

  logic [3:0]    w_mv;
  logic          w_one, w_ok, w_wall, w_move, w_exit;
  logic          w_play, w_tick, w_timeout, w_zero;
  logic [PW-1:0] w_tr, w_tc;
  logic [IW-1:0] w_idx;

  assign w_mv  = {mv_up, mv_down, mv_left, mv_right};
  assign w_one = (w_mv != 4'd0) && ((w_mv & (w_mv - 4'd1)) == 4'd0);

  // Target cell and in-grid check; simultaneous strobes give no move.
  always_comb begin
    w_tr = r_row;
    w_tc = r_col;
    w_ok = 1'b0;
    if (mv_up) begin
      w_ok = (r_row != '0);
      w_tr = r_row - 1'b1;
    end else if (mv_down) begin
      w_ok = (r_row != PW'(GRID - 1));
      w_tr = r_row + 1'b1;
    end else if (mv_left) begin
      w_ok = (r_col != '0);
      w_tc = r_col - 1'b1;
    end else if (mv_right) begin
      w_ok = (r_col != PW'(GRID - 1));
      w_tc = r_col + 1'b1;
    end
    w_ok = w_ok && w_one;
  end

  assign w_idx     = IW'(32'(w_tr) * GRID + 32'(w_tc));
  assign w_wall    = w_ok && wall_map[w_idx];
  assign w_move    = w_ok && !wall_map[w_idx];
  assign w_exit    = w_move && (w_tr == PW'(EXIT_ROW)) && (w_tc == PW'(EXIT_COL));
  assign w_play    = (r_state == ST_PLAY);
  assign w_tick    = sec_tick && w_play && !w_zero;
  assign w_timeout = w_tick && (time_tens == 4'd0) && (time_ones == 4'd1);

  bcd_down_counter #(.RST_VAL(TIME_BCD)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (start),
    .i_load_val (TIME_BCD),
    .i_en       (w_tick),
    .i_freeze   (r_done),
    .o_tens     (time_tens),
    .o_ones     (time_ones),
    .o_zero     (w_zero)
  );

  // Move results (WIN/CRASH) outrank a timeout on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_PLAY;
      r_row   <= ST_R;
      r_col   <= ST_C;
      r_lives <= LIVES_INIT;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= ST_PLAY;
      r_row   <= ST_R;
      r_col   <= ST_C;
      r_lives <= LIVES_INIT;
      r_done  <= 1'b0;
    end else if (w_play) begin
      if (w_wall) begin
`ifdef MAZE_LIVES_EN
        if (r_lives == 4'd1) begin
          r_state <= ST_CRASH;
          r_done  <= 1'b1;
          r_lives <= 4'd0;
        end else begin
          r_lives <= r_lives - 4'd1;
          r_row   <= ST_R;
          r_col   <= ST_C;
          if (w_timeout) begin
            r_state <= ST_TIMEOUT;
            r_done  <= 1'b1;
          end
        end
`else
        r_state <= ST_CRASH;
        r_done  <= 1'b1;
`endif
      end else if (w_exit) begin
        r_row   <= w_tr;
        r_col   <= w_tc;
        r_state <= ST_WIN;
        r_done  <= 1'b1;
      end else begin
        if (w_move) begin
          r_row <= w_tr;
          r_col <= w_tc;
        end
        if (w_timeout) begin
          r_state <= ST_TIMEOUT;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign pos_row    = r_row;
  assign pos_col    = r_col;
  assign state      = r_state;
  assign lives_left = r_lives;
  assign done       = r_done;

endmodule

// File: doc/maze_game_ctrl.md
# maze_game_ctrl

Parametrised game controller for the LED-matrix maze. It tracks player position on a GRID×GRID board, checks every move against a wall map, and runs a BCD countdown. It resolves each game into WIN, CRASH or TIMEOUT and freezes the timer on every terminal outcome. It sits between the keypad decode/debounce path and the matrix/seven-segment display muxes, and supports restart without a hardware reset.

## Interface
- GRID, 8, board edge length; legal range 2..16.
- TIME_SEC, 20, countdown start value in seconds; legal range 1..99.
- START_ROW / START_COL, 7 / 0, player start cell (row 0 = top).
- EXIT_ROW / EXIT_COL, 0 / 5, goal cell.
- LIVES, 3, crash budget; used only with MAZE_LIVES_EN.
- PW, $clog2(GRID), width of the position fields (localparam).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-cycle 1 Hz enable.
- start  in  1  one-cycle restart strobe.
- mv_up / mv_down / mv_left / mv_right  in  1 each  one-cycle move strobes, already debounced.
- wall_map  in  GRID*GRID  wall bit per cell, index row*GRID+col; 1 = wall.
- pos_row / pos_col  out  PW each  current player cell.
- state  out  2  game state: 0 PLAY, 1 WIN, 2 CRASH, 3 TIMEOUT.
- time_tens / time_ones  out  4 each  remaining time as BCD.
- lives_left  out  4  remaining lives; tied to 0 without MAZE_LIVES_EN.
- done  out  1  high in WIN, CRASH or TIMEOUT.

## Operation
- Reset values: state=PLAY, pos=(START_ROW,START_COL), time=TIME_SEC as BCD, lives_left=LIVES (or 0 without the macro), done=0.
- PLAY, move handling:
  - A cycle with exactly one move strobe high computes the target cell.
  - Zero strobes, or two or more strobes high in the same cycle: no move.
  - A target outside the grid is ignored: position is held and nothing is flagged.
  - Target is a wall: the player does not enter the cell and the CRASH path runs.
  - Target equals the exit: position is updated and state goes to WIN.
  - Any other target: position is updated.
- PLAY, timer: on sec_tick the BCD count decrements; a ones digit of 0 borrows (ones=9, tens−1). When the count reaches 00, state goes to TIMEOUT on the same edge.
- Terminal states (WIN, CRASH, TIMEOUT): the timer is frozen, moves are ignored, and outputs hold until start or reset.
- start, from any state: returns to PLAY, reloads pos to the start cell and time to TIME_SEC, reloads lives to LIVES, and clears done.
- Priority within one cycle: reset > start > move result (WIN/CRASH) > timeout tick. A move result and the last tick on the same edge resolve to the move result.
- A start on the same edge as a move: start wins and the move is discarded.
- A START cell coinciding with a wall is illegal; the testbench asserts against it.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Move strobe at edge N: pos/state are valid after edge N.
- sec_tick at edge N: time digits are updated after edge N.
- start at edge N: PLAY state and reloaded values are visible after edge N.
- Reset asserts asynchronously; deassertion is synchronised externally.

## Configuration
- MAZE_LIVES_EN defined:
  - A wall hit decrements lives_left and returns pos to the start cell. The timer keeps running and state stays PLAY.
  - CRASH is entered only when lives_left is 1 at the time of a hit; lives_left then shows 0.
- MAZE_LIVES_EN undefined: the first wall hit enters CRASH, and lives_left is constant 0.

## Structure
- Shared package maze_pkg holds the state encodings (ST_PLAY, ST_WIN, ST_CRASH, ST_TIMEOUT) and the BCD constant for 00.
- Sub-module bcd_down_counter: 2-digit BCD down counter with load value, enable, freeze, and a zero flag. It is reusable by other lab timers.
- Move/collision evaluation and the FSM live in maze_game_ctrl itself.

## Test plan
- Reset with defaults, then 20 sec_ticks with no moves -> time counts 20,19,…,01,00; state=TIMEOUT after the 20th tick; done=1; further ticks leave 00.
- Walk a wall-free path to (0,5) -> state=WIN on the final move edge; later ticks leave time frozen, e.g. at 14.
- From start, press mv_up into a wall cell (macro off) -> state=CRASH, pos unchanged at (7,0), timer frozen.
- Macro on, LIVES=3: three wall hits -> lives 2,1 with pos reset to (7,0) after each of the first two; the third hit gives CRASH and lives_left=0.
- mv_left at column 0, and mv_up+mv_right in the same cycle -> no position change, state stays PLAY.
- Last tick and winning move on the same edge -> WIN. Afterwards start -> PLAY, time=20, pos=(7,0); reset asserted mid-game -> immediate reset values.
